// File: rtl/rsa_modexp_arbiter.sv
// rsa_modexp_arbiter: round-robin sharing of one modexp engine between two ports.
// Optional WAIT watchdog with engine abort is enabled by defining RSA_ARB_TIMEOUT_EN.
module rsa_modexp_arbiter #(
    parameter int WIDTH = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] base0,
    input  logic [WIDTH-1:0] exp0,
    input  logic [WIDTH-1:0] mod0,
    input  logic             req1,
    input  logic [WIDTH-1:0] base1,
    input  logic [WIDTH-1:0] exp1,
    input  logic [WIDTH-1:0] mod1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result0,
    output logic [WIDTH-1:0] result1,
    output logic             err0,
    output logic             err1,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_base,
    output logic [WIDTH-1:0] eng_exp,
    output logic [WIDTH-1:0] eng_mod,
    output logic             eng_abort,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_result
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic owner, last_served, pick, timeout, finish;

    // a lone request wins outright; a tie goes to the port not served last
    assign pick = (req0 && req1) ? ~last_served : req1;
    assign finish = state == WAIT && (eng_done || timeout);

`ifdef RSA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic aborted;
    assign timeout = state == WAIT && !eng_done && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            aborted <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
        end else begin
            cnt <= state == WAIT ? cnt + 1'b1 : '0;
            aborted <= timeout;
            if (finish && !owner) err0 <= timeout;
            if (finish && owner) err1 <= timeout;
        end
    end
    assign eng_abort = state == RESP && aborted;
`else
    assign timeout = 1'b0;
    assign err0 = 1'b0;
    assign err1 = 1'b0;
    assign eng_abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE  ? ((req0 || req1) ? ISSUE : IDLE) :
                   state == ISSUE ? WAIT :
                   state == WAIT  ? (finish ? RESP : WAIT) : IDLE;
    end

    always_comb begin
        gnt0 = state == ISSUE && !owner;
        gnt1 = state == ISSUE && owner;
        done0 = state == RESP && !owner;
        done1 = state == RESP && owner;
        eng_start = state == ISSUE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner <= 1'b0;
            last_served <= 1'b1;
            eng_base <= '0;
            eng_exp <= '0;
            eng_mod <= '0;
            result0 <= '0;
            result1 <= '0;
        end else begin
            if (state == IDLE && (req0 || req1)) begin
                owner <= pick;
                eng_base <= pick ? base1 : base0;
                eng_exp <= pick ? exp1 : exp0;
                eng_mod <= pick ? mod1 : mod0;
            end
            // a watchdog abort leaves a zero result
            if (finish && !owner) result0 <= eng_done ? eng_result : '0;
            if (finish && owner) result1 <= eng_done ? eng_result : '0;
            if (state == RESP) last_served <= owner;
        end
    end
endmodule

// File: tb/tb_rsa_modexp_arbiter.sv
// tb_rsa_modexp_arbiter: randomized and directed checks against a modexp/round-robin reference model.
module tb_rsa_modexp_arbiter;
    logic clk = 0, reset = 1;
    logic req0 = 0, req1 = 0;
    logic [63:0] base0 = 0, exp0 = 0, mod0 = 0, base1 = 0, exp1 = 0, mod1 = 0;
    logic gnt0, gnt1, done0, done1, err0, err1, eng_start, eng_abort;
    logic [63:0] result0, result1, eng_base, eng_exp, eng_mod;
    logic eng_done = 0;
    logic [63:0] eng_result = 0;

    int pass_cnt = 0, total = 0, cyc = 0, done_cyc = -100, gnt_cyc = 0;
    int eng_lat = 10;
    bit eng_hang = 0;
    bit last = 1;
    logic [63:0] res_m [2] = '{64'd0, 64'd0};

    rsa_modexp_arbiter #(.WIDTH(64), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .base0(base0), .exp0(exp0), .mod0(mod0),
        .req1(req1), .base1(base1), .exp1(exp1), .mod1(mod1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result0(result0), .result1(result1), .err0(err0), .err1(err1),
        .eng_start(eng_start), .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
        .eng_abort(eng_abort), .eng_done(eng_done), .eng_result(eng_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] modexp(input logic [63:0] b, e, m);
        logic [127:0] r, x;
        r = 128'(1 % m);
        x = 128'(b % m);
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * x) % m;
            x = (x * x) % m;
        end
        return r[63:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // engine model: completes eng_lat cycles after eng_start unless told to hang
    always begin : engine
        bit pend;
        int left;
        logic [63:0] res;
        @(posedge clk);
        #1;
        eng_done = 0;
        if (reset || eng_abort) pend = 0;
        else if (pend) begin
            if (left <= 1) begin
                eng_done = 1;
                eng_result = res;
                done_cyc = cyc;
                pend = 0;
            end else left--;
        end else if (eng_start) begin
            pend = !eng_hang;
            left = eng_lat;
            res = modexp(eng_base, eng_exp, eng_mod);
        end
    end

    task automatic do_reset;
        #1 reset = 1;
        tick;
        tick;
        check("rst_ctl", {gnt0, gnt1, done0, done1, err0, err1, eng_start, eng_abort}, 0);
        check("rst_res", result0 | result1, 0);
        check("rst_eng", eng_base | eng_exp | eng_mod, 0);
        reset = 0;
        last = 1;
        res_m = '{64'd0, 64'd0};
    endtask

    task automatic rand_ops;
        base0 = {$urandom, $urandom}; exp0 = {$urandom, $urandom}; mod0 = {$urandom, $urandom} | 64'd2;
        base1 = {$urandom, $urandom}; exp1 = {$urandom, $urandom}; mod1 = {$urandom, $urandom} | 64'd2;
    endtask

    task automatic do_op(input bit r0, input bit r1, input int lat, input int dly, input bit hold);
        bit p, held_bad;
        int n;
        logic [63:0] er;
        p = (r0 && r1) ? !last : r1;
        er = p ? modexp(base1, exp1, mod1) : modexp(base0, exp0, mod0);
        eng_lat = lat;
        req0 = r0;
        req1 = r1;
        n = 0;
        do begin tick; n++; end while (!(gnt0 || gnt1) && n < 20);
        check("gnt_delay", n, dly);
        check("gnt_port", {gnt1, gnt0}, p ? 2 : 1);
        check("eng_start", eng_start, 1);
        check("eng_base", eng_base, p ? base1 : base0);
        check("eng_exp", eng_exp, p ? exp1 : exp0);
        check("eng_mod", eng_mod, p ? mod1 : mod0);
        gnt_cyc = cyc;
        if (!hold) begin
            if (p) req1 = 0;
            else req0 = 0;
        end
        n = 0;
        held_bad = 0;
        tick;
        check("no_double_gnt", {gnt1, gnt0, eng_start}, 0);
        while (!(done0 || done1) && n < lat + 20) begin
            if ((p ? result1 : result0) !== res_m[p]) held_bad = 1;
            tick;
            n++;
        end
        check("held", held_bad, 0);
        check("done_port", {done1, done0}, p ? 2 : 1);
        check("done_lat", cyc - done_cyc, 1);
        check("result", p ? result1 : result0, er);
        check("other_result", p ? result0 : result1, res_m[!p]);
        check("err", {err1, err0, eng_abort}, 0);
        res_m[p] = er;
        last = p;
    endtask

    initial begin
        int g0, dc, g, abort_cyc, done_at;
        bit saw_done, saw_abort, saw_err;
        logic [63:0] r_at;
        logic [1:0] e_at;
        logic [1:0] r;
        tick;
        do_reset;
        tick;

        base0 = 5; exp0 = 3; mod0 = 33;
        do_op(1, 0, 10, 1, 0);
        check("single_r0", result0, 26);
        check("single_r1", result1, 0);

        do_reset;
        tick;
        base1 = 26; exp1 = 7; mod1 = 33;
        do_op(1, 1, 10, 1, 0);
        g0 = gnt_cyc;
        check("tie_r0", result0, 26);
        do_op(0, 1, 10, 2, 0);
        check("tie_r1", result1, 5);
        check("gnt_spacing", (gnt_cyc - g0) >= 4, 1);
        tick;

        rand_ops;
        do_op(1, 1, $urandom_range(1, 8), 1, 1);
        for (int i = 0; i < 5; i++) do_op(1, 1, $urandom_range(1, 8), 2, 1);
        req0 = 0; req1 = 0;
        tick;

        do_op(0, 1, 5, 1, 0);
        dc = cyc;
        tick;
        base1 = {$urandom, $urandom}; exp1 = {$urandom, $urandom};
        do_op(0, 1, 8, 1, 0);
        check("b2b_gap", gnt_cyc - dc, 2);
        tick;

        rand_ops;
        eng_lat = 12;
        req0 = 1;
        tick;
        check("mid_gnt", gnt0, 1);
        req0 = 0;
        repeat (3) tick;
        #2 reset = 1;
        #1;
        check("mid_ctl", {gnt0, gnt1, done0, done1, err0, err1, eng_start, eng_abort}, 0);
        check("mid_res", result0 | result1, 0);
        check("mid_eng", eng_base | eng_exp | eng_mod, 0);
        tick;
        reset = 0;
        last = 1;
        res_m = '{64'd0, 64'd0};
        saw_done = 0;
        repeat (15) begin tick; if (done0 || done1) saw_done = 1; end
        check("mid_no_done", saw_done, 0);
        do_op(1, 0, 6, 1, 0);
        tick;

        eng_hang = 1;
        rand_ops;
        req0 = 1;
        tick;
        check("hang_gnt", gnt0, 1);
        g = cyc;
        req0 = 0;
        saw_done = 0; saw_abort = 0; saw_err = 0; abort_cyc = 0; done_at = 0;
        r_at = '1; e_at = 0;
        repeat (40) begin
            tick;
            if (eng_abort && !saw_abort) abort_cyc = cyc;
            if (done0 && !saw_done) begin done_at = cyc; r_at = result0; e_at = {err1, err0}; end
            saw_abort |= eng_abort;
            saw_done |= done0 | done1;
            saw_err |= err0 | err1;
        end
`ifdef RSA_ARB_TIMEOUT_EN
        check("to_abort_at", abort_cyc - g, 17);
        check("to_done_at", done_at - g, 17);
        check("to_result", r_at, 0);
        check("to_err", e_at, 2'b01);
`else
        check("hang_no_done", saw_done, 0);
        check("hang_no_abort", saw_abort, 0);
        check("hang_no_err", saw_err, 0);
`endif
        eng_hang = 0;
        do_reset;
        tick;

        for (int i = 0; i < 8; i++) begin
            rand_ops;
            r = 2'($urandom_range(1, 3));
            do_op(r[0], r[1], $urandom_range(1, 12), 1, 0);
            req0 = 0; req1 = 0;
            tick;
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
